// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and word width for the SPI master.
package spi_pkg;
    localparam int BITS = 8;
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick every DIV enabled cycles, restarting whenever enable drops.
module spi_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == 8'(DIV - 1));
    always_comb cnt_d = (!en || tick) ? 8'd0 : cnt_q + 8'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI byte master with SETUP/XFER/HOLD framing around 16 SCLK half-periods.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            START,
    input  logic [BITS-1:0] TX_DATA,
    input  logic            MISO,
    output logic            SCLK,
    output logic            MOSI,
    output logic            CS_N,
    output logic            BUSY,
    output logic            DONE,
    output logic [BITS-1:0] RX_DATA
);
    state_e          state_q, state_d;
    logic [BITS-1:0] shift_q, shift_d, rx_q, rx_d;
    logic [3:0]      edge_q, edge_d;
    logic            sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
    logic            tick;

    spi_clk_div #(.DIV(DIV)) u_div (
        .clk  (CLK),
        .rst_n(CLR),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // The shifter takes MISO on the rising edge while MOSI is a separate flop
    // reloaded from the shifter MSB on falling edges, so TX bits are never lost.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rx_d    = rx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                state_d = SETUP;
                shift_d = TX_DATA;
                mosi_d  = TX_DATA[BITS-1];
                edge_d  = 4'd0;
            end
            SETUP: if (tick) begin
                state_d = XFER;
                edge_d  = 4'd0;
            end
            XFER: if (tick) begin
                sclk_d  = !sclk_q;
                edge_d  = edge_q + 4'd1;
                shift_d = !sclk_q ? {shift_q[BITS-2:0], MISO} : shift_q;
                mosi_d  = (sclk_q && edge_q != 4'd15) ? shift_q[BITS-1] : mosi_q;
                state_d = (edge_q == 4'd15) ? HOLD : XFER;
            end
            HOLD: if (tick) begin
                state_d = IDLE;
                done_d  = 1'b1;
                rx_d    = shift_q;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            shift_q <= '0;
            edge_q  <= 4'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
        end
    end

    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign CS_N    = (state_q == IDLE);
    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign RX_DATA = rx_q;
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning system-clock cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  transfer request, sampled only in IDLE.
REQ-005 SHALL have port TX_DATA  input  8  byte to send, captured on accepted START.
REQ-006 SHALL have port MISO  input  1  serial data from slave.
REQ-007 SHALL have port SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-008 SHALL have port MOSI  output  1  serial data to slave, MSB first.
REQ-009 SHALL have port CS_N  output  1  slave select, active-low.
REQ-010 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RX_DATA  output  8  received byte, held until the next completion.

Function
REQ-013 SHALL implement states IDLE, SETUP, XFER and HOLD.
REQ-014 SHALL accept START in IDLE: next cycle state=SETUP, CS_N=0, BUSY=1, 8-bit shifter=TX_DATA, MOSI=TX_DATA[7].
REQ-015 SHALL remain in SETUP for DIV cycles with SCLK=0, then enter XFER.
REQ-016 SHALL run XFER as 16 half-periods of DIV cycles each, toggling SCLK at every half-period boundary, for 8 rising edges.
REQ-017 SHALL shift MISO into the shifter LSB on each SCLK rising edge.
REQ-018 SHALL shift the shifter left on each SCLK falling edge except the 8th, presenting the next bit on MOSI.
REQ-019 SHALL enter HOLD after the 8th falling edge, keeping CS_N=0 and SCLK=0 for DIV cycles.
REQ-020 SHALL leave HOLD to IDLE with CS_N=1, BUSY=0, DONE=1 for exactly one cycle, and RX_DATA=shifter, all in the same cycle.
REQ-021 SHALL keep CS_N low for exactly 18*DIV consecutive cycles per transfer.
REQ-022 SHALL ignore START while BUSY=1, with no effect on the shifter, TX capture or timing.
REQ-023 SHALL accept START in the DONE cycle, since the state is IDLE in that cycle, giving back-to-back transfers with CS_N high for exactly 1 cycle.
REQ-024 SHALL hold MOSI=0 and SCLK=0 in IDLE.
REQ-025 SHALL use a half-period counter wide enough for DIV=255 and an edge counter of 0..15, both wrapping to 0 on state entry.

Reset
REQ-026 SHALL on CLR=0, at any time including mid-transfer, immediately force state=IDLE, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, RX_DATA=8'h00 and clear the shifter and counters.
REQ-027 SHALL NOT generate DONE or update RX_DATA for a transfer aborted by reset.
REQ-028 SHALL accept START on the first rising CLK edge after CLR deasserts.

Structure
REQ-029 SHALL place state encoding (IDLE/SETUP/XFER/HOLD) and the constant BITS=8 in shared package spi_pkg.
REQ-030 SHALL use one sub-module, spi_clk_div, which generates a one-cycle half-period tick every DIV cycles while enabled and restarts on enable.
REQ-031 SHALL keep the FSM, shifter and edge counter in spi_master_ctrl.

Verification
REQ-032 SHALL cover loopback: DIV=2, MISO=MOSI, START with TX_DATA=8'hA5 -> RX_DATA=8'hA5, DONE pulse once, CS_N low 36 cycles, 8 SCLK rising edges.
REQ-033 SHALL cover fixed MISO: DIV=1, MISO=1, TX_DATA=8'h00 -> MOSI=0 throughout, RX_DATA=8'hFF, CS_N low 18 cycles.
REQ-034 SHALL cover ignored START: START with TX_DATA=8'h3C, then START with 8'hFF at cycle 5 of the transfer -> single transfer, MOSI bit sequence 0,0,1,1,1,1,0,0.
REQ-035 SHALL cover back-to-back transfers: START asserted in the DONE cycle with TX_DATA=8'h81 -> second transfer starts, CS_N high exactly 1 cycle between transfers.
REQ-036 SHALL cover reset mid-transfer: CLR=0 after the 3rd SCLK rise -> outputs at reset values that cycle, no DONE, RX_DATA=8'h00, next START completes normally.
